// File: rtl/conv_33_seq.sv
// Sequencer for the 3x3 / stride-1 / pad-1 convolution datapath.
// It loads the kernel, zero-pads the source raster, and tracks which datapath outputs are valid.
module conv_33_seq #(
   parameter int D          = 220,
   parameter int DATA_WIDTH = 32,
   parameter int LAT        = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    kw_valid,
   input  logic [DATA_WIDTH-1:0]   kw_data,
   output logic [9*DATA_WIDTH-1:0] kernel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_pxl,
   output logic                    dp_en,
   output logic [DATA_WIDTH-1:0]   dp_pxl,
   output logic                    res_valid,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int PW   = $clog2(D + 2);
   localparam int NPOS = (D + 2) * (D + 2);
   localparam int AW   = $clog2(NPOS + 1);
   localparam int DCW  = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_K = 2'd1,
      S_STREAM = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t                  r_state;
   logic [3:0]              r_kidx;
   logic [9*DATA_WIDTH-1:0] r_kernel;
   logic [PW-1:0]           r_row;
   logic [PW-1:0]           r_col;
   logic [AW-1:0]           r_adv;
   logic [DCW-1:0]          r_dcnt;
   logic [LAT-1:0]          r_tag;
   logic                    r_frame_done;

   logic                    w_border;
   logic                    w_in_ready;
   logic                    w_dp_en;
   logic [DATA_WIDTH-1:0]   w_dp_pxl;
   logic                    w_tag;

   // Padded-stream steering: borders inject zeros, interior positions wait on the source.
   always_comb begin
      w_border   = (r_row == PW'(0)) || (r_row == PW'(D + 1)) ||
                   (r_col == PW'(0)) || (r_col == PW'(D + 1));
      w_in_ready = 1'b0;
      w_dp_en    = 1'b0;
      w_dp_pxl   = '0;
      w_tag      = 1'b0;
      case (r_state)
         S_STREAM: begin
            w_tag = (r_row >= PW'(2)) && (r_col >= PW'(2));
            if (w_border) begin
               w_dp_en = 1'b1;
            end else begin
               w_in_ready = 1'b1;
               if (in_valid) begin
                  w_dp_en  = 1'b1;
                  w_dp_pxl = in_pxl;
               end else begin
                  w_dp_en = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            // The frame_done cycle itself does not advance the datapath.
            w_dp_en = ~r_frame_done;
         end
         default: begin
            w_dp_en = 1'b0;
         end
      endcase
   end

   // Sequencer FSM, kernel bank, position counters and valid-tag pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_kidx       <= 4'd0;
         r_kernel     <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_adv        <= '0;
         r_dcnt       <= '0;
         r_tag        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_dp_en) begin
            r_tag[0] <= w_tag;
            for (int i = 1; i < LAT; i++) begin
               r_tag[i] <= r_tag[i-1];
            end
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_LOAD_K;
                  r_kidx  <= 4'd0;
               end
            end
            S_LOAD_K: begin
               if (kw_valid) begin
                  r_kernel[int'(r_kidx)*DATA_WIDTH +: DATA_WIDTH] <= kw_data;
                  r_kidx <= r_kidx + 4'd1;
                  if (r_kidx == 4'd8) begin
                     r_state <= S_STREAM;
                     r_row   <= '0;
                     r_col   <= '0;
                     r_adv   <= '0;
                  end
               end
            end
            S_STREAM: begin
               if (w_dp_en) begin
                  r_adv <= r_adv + AW'(1);
                  if (r_col == PW'(D + 1)) begin
                     r_col <= '0;
                     r_row <= (r_row == PW'(D + 1)) ? PW'(0) : r_row + PW'(1);
                  end else begin
                     r_col <= r_col + PW'(1);
                  end
                  if (r_adv == AW'(NPOS - 1)) begin
                     r_state <= S_DRAIN;
                     r_adv   <= '0;
                     r_dcnt  <= '0;
                  end
               end
            end
            S_DRAIN: begin
               if (r_frame_done) begin
                  r_frame_done <= 1'b0;
                  r_state      <= S_IDLE;
               end else begin
                  r_dcnt <= r_dcnt + DCW'(1);
                  if (r_dcnt == DCW'(LAT - 1)) begin
                     r_frame_done <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign kernel     = r_kernel;
   assign in_ready   = w_in_ready;
   assign dp_en      = w_dp_en;
   assign dp_pxl     = w_dp_pxl;
   assign res_valid  = r_tag[LAT-1] & w_dp_en;
   assign busy       = (r_state != S_IDLE);
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_33_seq.sv
// Directed/randomised bench for conv_33_seq at D=4, LAT=2.
// Expected streams come from the padding and window rules evaluated per advance index.
module tb_conv_33_seq;

   localparam int D    = 4;
   localparam int DW   = 32;
   localparam int LAT  = 2;
   localparam int N    = D + 2;
   localparam int NADV = N * N;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            kw_valid = 1'b0;
   logic [DW-1:0]   kw_data = '0;
   logic [9*DW-1:0] kernel;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DW-1:0]   in_pxl = '0;
   logic            dp_en;
   logic [DW-1:0]   dp_pxl;
   logic            res_valid;
   logic            busy;
   logic            frame_done;

   int n_assert = 0;
   int n_fail   = 0;
   logic [DW-1:0] pix [D*D];

   conv_33_seq #(.D(D), .DATA_WIDTH(DW), .LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start),
      .kw_valid(kw_valid), .kw_data(kw_data), .kernel(kernel),
      .in_valid(in_valid), .in_ready(in_ready), .in_pxl(in_pxl),
      .dp_en(dp_en), .dp_pxl(dp_pxl), .res_valid(res_valid),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_border(input int j);
      return (j / N == 0) || (j / N == N - 1) || (j % N == 0) || (j % N == N - 1);
   endfunction

   // A window is complete when its bottom-right pixel (row>=2, col>=2) enters.
   function automatic bit win_tag(input int k);
      return (k < NADV) && (k / N >= 2) && (k % N >= 2);
   endfunction

   function automatic logic [DW-1:0] pad_val(input int j);
      if (j >= NADV || is_border(j)) return '0;
      return pix[(j / N - 1) * D + (j % N - 1)];
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_dp_en"}, 32'(dp_en), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_dp_pxl"}, dp_pxl, 32'd0);
   endtask

   // Starts from just after a negedge; returns just after the negedge of STREAM cycle 0.
   task automatic load_kernel(input logic [DW-1:0] base);
      start = 1'b1;
      #1;
      chk("start_from_idle", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         int gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            kw_valid = 1'b0;
            #1;
            chk("loadk_gap_busy", 32'(busy), 32'd1);
            chk("loadk_gap_dp_en", 32'(dp_en), 32'd0);
            @(negedge clk);
         end
         kw_valid = 1'b1;
         kw_data  = base + DW'(i);
         #1;
         chk("loadk_dp_en", 32'(dp_en), 32'd0);
         @(negedge clk);
      end
      kw_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         chk("kernel_slot", kernel[i*DW +: DW], base + DW'(i));
      end
   endtask

   // mode 0: source always valid, 1: valid toggles 1,0,..., 2: random valid.
   task automatic run_frame(input int mode, input int abort_at, input bit b2b);
      int j = 0, p = 0, cyc = 0, rv_cnt = 0, rdy_cnt = 0;
      int first_rv = -1, done_cyc = -1;
      bit iv, brd, exp_en, exp_rdy, exp_done, exp_rv, done, aborted;
      logic [DW-1:0] exp_px;
      done = 1'b0;
      aborted = 1'b0;
      for (int k = 0; k < D*D; k++) pix[k] = $urandom;
      while (!done && cyc < 400) begin
         if (abort_at >= 0 && j == abort_at) begin
            reset    = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            reset    = 1'b0;
            in_valid = 1'b0;
            #1;
            chk_idle("abort");
            chk("abort_kernel_cleared", kernel[DW-1:0], 32'd0);
            for (int k = 0; k < 45; k++) begin
               @(negedge clk);
               #1;
               chk("abort_no_done", 32'(frame_done), 32'd0);
               chk("abort_no_dp_en", 32'(dp_en), 32'd0);
            end
            @(negedge clk);
            done = 1'b1;
            aborted = 1'b1;
         end else begin
            iv = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            kw_valid = (cyc == 0);
            kw_data  = 32'hDEAD_BEEF;
            in_valid = iv;
            in_pxl   = (p < D*D) ? pix[p] : $urandom;
            start    = b2b && (j == NADV + LAT);
            brd      = (j < NADV) ? is_border(j) : 1'b1;
            if (j < NADV) begin
               exp_en = brd || iv; exp_rdy = !brd; exp_done = 1'b0;
            end else if (j < NADV + LAT) begin
               exp_en = 1'b1; exp_rdy = 1'b0; exp_done = 1'b0;
            end else begin
               exp_en = 1'b0; exp_rdy = 1'b0; exp_done = 1'b1;
            end
            exp_px = pad_val(j);
            exp_rv = exp_en && (j >= LAT) && win_tag(j - LAT);
            #1;
            chk("dp_en", 32'(dp_en), 32'(exp_en));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("res_valid", 32'(res_valid), 32'(exp_rv));
            if (exp_en) chk("dp_pxl", dp_pxl, exp_px);
            if (res_valid === 1'b1) begin
               rv_cnt++;
               if (first_rv < 0) first_rv = cyc;
            end
            if (in_ready === 1'b1) rdy_cnt++;
            if (exp_done) begin
               done = 1'b1;
               done_cyc = cyc;
            end
            if (exp_en && j < NADV && !brd) p++;
            if (exp_en) j++;
            cyc++;
            @(negedge clk);
         end
      end
      start = 1'b0; in_valid = 1'b0; kw_valid = 1'b0;
      if (!done) chk("frame_timeout", 32'd0, 32'd1);
      else if (!aborted) begin
         chk("res_valid_count", 32'(rv_cnt), 32'(D*D));
         chk("pixels_consumed", 32'(p), 32'(D*D));
         if (mode == 0) begin
            chk("in_ready_count", 32'(rdy_cnt), 32'(D*D));
            chk("first_res_valid_cycle", 32'(first_rv), 32'(N*2 + 2 + LAT));
            chk("frame_done_cycle", 32'(done_cyc), 32'(NADV + LAT));
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk_idle("reset");
      chk("reset_kernel_lo", kernel[DW-1:0], 32'd0);
      chk("reset_kernel_hi", kernel[9*DW-1 -: DW], 32'd0);
      @(negedge clk);
      reset = 1'b0;
      kw_valid = 1'b1;
      kw_data = 32'h1234_5678;
      in_valid = 1'b1;
      #1;
      chk_idle("idle");
      @(negedge clk);
      kw_valid = 1'b0;
      in_valid = 1'b0;
      chk("idle_kw_ignored", kernel[DW-1:0], 32'd0);

      // Start with no kernel words: the sequencer must sit in LOAD_K.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("loadk_hold_busy", 32'(busy), 32'd1);
         chk("loadk_hold_dp_en", 32'(dp_en), 32'd0);
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_idle("loadk_reset");
      chk("loadk_reset_kernel", kernel[DW-1:0], 32'd0);
      @(negedge clk);

      load_kernel(32'd1);
      run_frame(0, -1, 1'b0);
      for (int i = 0; i < 9; i++) chk("kernel_kept", kernel[i*DW +: DW], 32'(i + 1));

      load_kernel(32'h100);
      run_frame(1, -1, 1'b0);

      load_kernel(32'h200);
      run_frame(0, 3 * N + 2, 1'b0);

      load_kernel(32'h300);
      run_frame(2, -1, 1'b0);

      load_kernel(32'h400);
      run_frame(0, -1, 1'b1);
      load_kernel(32'h500);
      run_frame(0, -1, 1'b0);
      for (int i = 0; i < 9; i++) chk("kernel_reload", kernel[i*DW +: DW], 32'h500 + 32'(i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_33_seq.md
Name: conv_33_seq

Overview:
- Controller/sequencer for the 3x3, stride-1, pad-1 convolution datapath.
- Loads the nine kernel coefficients.
- Accepts an unpadded D×D pixel stream through a valid/ready handshake and emits the zero-padded (D+2)×(D+2) stream to the datapath. The datapath advances only on a per-cycle enable.
- Generates an exact output-valid mask, aligned to the datapath latency, plus frame start/done status.
- Sits between the pixel source (memory/DMA) and the MAC array.

Parameters:
- D, 220: unpadded frame side, in pixels.
- DATA_WIDTH, 32: pixel and coefficient width.
- LAT, 2: datapath latency in enabled cycles, from a padded pixel entering to that window's result at the datapath output. Range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins kernel load then frame; ignored unless IDLE
- kw_valid  in  1  kernel word strobe
- kw_data  in  DATA_WIDTH  kernel word; order k00..k08 (row-major)
- kernel  out  9*DATA_WIDTH  coefficient bank; k00 at bits [DATA_WIDTH-1:0]
- in_valid  in  1  source pixel valid
- in_ready  out  1  sequencer accepts pixel
- in_pxl  in  DATA_WIDTH  source pixel, raster order
- dp_en  out  1  datapath advance enable
- dp_pxl  out  DATA_WIDTH  padded pixel to datapath
- res_valid  in-mask  out  1  datapath output this cycle is a valid interior result
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of DRAIN

Behaviour:
- Reset values: every output is 0, kernel bank cleared, FSM in IDLE, all counters 0. Reset mid-frame aborts immediately with no frame_done; the datapath receives no further dp_en.
- FSM states: IDLE, LOAD_K, STREAM, DRAIN.
- IDLE to LOAD_K: on start.
- LOAD_K:
  - Each kw_valid writes kw_data to slot kidx, then kidx increments.
  - On the ninth word, move to STREAM the next cycle.
  - Kernel words outside LOAD_K are ignored.
  - The kernel bank holds its value until the next LOAD_K.
- STREAM: walks padded position (r,c), with r,c in 0..D+1 and c fastest.
  - Border position (r=0, r=D+1, c=0 or c=D+1):
    - dp_pxl = 0, dp_en = 1, in_ready = 0.
    - Position advances unconditionally.
  - Interior position:
    - in_ready = 1.
    - If in_valid: dp_pxl = in_pxl, dp_en = 1, position advances.
    - Otherwise: dp_en = 0 and the position holds. This is a stall: the datapath freezes and no mask bit shifts.
  - dp_pxl/dp_en are combinational from the current position and the handshake. Zero bubbles exist when the source keeps in_valid high.
  - After (D+2)^2 advances, move to DRAIN.
- Valid mask:
  - Tag per advance = (r>=2 && c>=2). This marks the bottom-right corner of a full window.
  - Tags enter a LAT-deep shift register that advances only when the datapath advances.
  - res_valid = tail bit AND the tail-shift condition, so it is asserted for exactly one cycle per result.
  - Exactly D*D res_valid pulses per frame.
- DRAIN:
  - dp_en = 1, dp_pxl = 0 for LAT cycles, flushing the tags. Drain tags are 0.
  - Then pulse frame_done and return to IDLE.
- Counters:
  - Column and row wrap D+1 to 0.
  - Advance counter width is clog2((D+2)^2 + 1).
  - Simultaneous last-advance and stall is impossible, because the last position is a border position.
- start while busy is ignored. in_valid outside STREAM is ignored, with in_ready = 0.

Test Plan:
- Reset then idle: all outputs 0; a start pulse with no kernel words holds LOAD_K with busy=1; a reset there returns to IDLE and leaves kernel = 0.
- Kernel load with words 1..9, with gaps between strobes: kernel slot i = i+1 after the 9th strobe; STREAM entered the next cycle; extra kw_valid ignored.
- D=4, LAT=2, source always valid with pixels 1..16:
  - dp_pxl sequence is 36 values, zeros at borders.
  - in_ready high for exactly 16 cycles.
  - res_valid pulses exactly 16 times, first pulse 16 cycles after the first dp_en (position (2,2) at advance 14, plus LAT).
  - frame_done 38 cycles after STREAM entry.
- Same as above with in_valid toggling 1,0,1,0: stalls appear only at interior positions; dp_en low on every stall; the dp_pxl and res_valid sequences are identical to the no-stall case apart from timing.
- Reset asserted mid-STREAM at row 3: next cycle IDLE, dp_en=0, no frame_done; a subsequent start plus a full frame gives correct counts (16 res_valid).
- Back-to-back frames, with start in the cycle of frame_done and again one cycle later: the first start is ignored, the second is accepted; the second frame is correct and the kernel is reloaded.
